aidan_mcnay_div_pool: RTL and testbench
=======================================

AIDAN_MCNAY_DIV_POOL -- requirements
Module: aidan_mcnay_div_pool

Interface
REQ-001 SHALL have parameter nbits, default 16, operand/result width in bits (legal 2..32).
REQ-002 SHALL have parameter nunits, default 2, number of internal divider units (legal 1..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port opa  input  nbits  unsigned dividend.
REQ-006 SHALL have port opb  input  nbits  unsigned divisor.
REQ-007 SHALL have port istream_val  input  1  request valid.
REQ-008 SHALL have port istream_rdy  output  1  request accepted when val and rdy are both high at a rising edge.
REQ-009 SHALL have port quotient  output  nbits  opa / opb.
REQ-010 SHALL have port remainder  output  nbits  opa % opb.
REQ-011 SHALL have port ostream_val  output  1  result valid.
REQ-012 SHALL have port ostream_rdy  input  1  result consumed when val and rdy are both high at a rising edge.

Function
REQ-013 SHALL contain nunits restoring radix-2 dividers, each with states IDLE, BUSY and DONE.
REQ-014 SHALL keep an issue pointer and an output pointer, each modulo nunits.
REQ-015 SHALL drive istream_rdy high iff the unit at the issue pointer is IDLE.
REQ-016 SHALL, on an accepted request, load that unit, move it to BUSY and advance the issue pointer.
REQ-017 SHALL make each BUSY unit resolve one quotient bit per cycle, MSB first: R = (R<<1)|next opa bit; if R >= opb then R -= opb and bit = 1.
REQ-018 SHALL move a unit from BUSY to DONE at the nbits-th rising edge after its accepting edge, so ostream_val is high in the following cycle (latency nbits+1 cycles with ostream_rdy high).
REQ-019 SHALL drive ostream_val high iff the unit at the output pointer is DONE, with quotient and remainder taken from that unit.
REQ-020 SHALL return results strictly in acceptance order; a DONE unit not at the output pointer waits.
REQ-021 SHALL hold quotient and remainder stable while ostream_val is high and ostream_rdy is low.
REQ-022 SHALL, on an output handshake, return the unit to IDLE and advance the output pointer.
REQ-023 SHALL have no combinational path from ostream_rdy to istream_rdy; a unit freed at an edge accepts from the next cycle.
REQ-024 SHALL, with opb = 0, produce quotient = all ones and remainder = opa at normal latency, with no error stall.
REQ-025 SHALL keep the internal remainder register nbits+1 bits wide so that the compare cannot overflow at opb >= 2^(nbits-1).
REQ-026 SHALL keep quotient and remainder at 0 whenever ostream_val is low.

Reset
REQ-027 SHALL, while reset is high, put all units in IDLE, both pointers at 0, ostream_val = 0, quotient = 0 and remainder = 0.
REQ-028 SHALL drive istream_rdy low while reset is high and allow it to rise in the first cycle after reset deasserts.
REQ-029 SHALL, when reset is asserted mid-operation, discard all in-flight and DONE results without emitting them.

Configuration
REQ-030 SHALL, with macro AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN defined, add port div_by_zero  output  1, which is high with ostream_val when the emitted result had opb = 0, held under backpressure, and 0 at reset or when ostream_val is low.
REQ-031 SHALL, without the macro, omit the div_by_zero port and its per-unit flag storage, with all other behaviour unchanged.

Verification (nbits=16, nunits=2)
REQ-032 SHALL cover: 100/7 with ostream_rdy high -> quotient=14, remainder=2, ostream_val 17 cycles after acceptance.
REQ-033 SHALL cover: 0xFFFF/1 and 0x8000/0x8001 -> (0xFFFF,0) and (0,0x8000).
REQ-034 SHALL cover: 1234/0 -> quotient=0xFFFF, remainder=1234; div_by_zero=1 when the macro is defined.
REQ-035 SHALL cover: three back-to-back requests 50/5, 9/4, 7/7 with ostream_rdy low -> third istream_rdy stays low until the first output handshake; outputs emitted (10,0),(2,1),(1,0) in order.
REQ-036 SHALL cover: ostream_rdy held low 30 cycles after both units are DONE -> outputs are stable, exactly 2 requests are accepted, and nothing is lost when rdy rises.
REQ-037 SHALL cover: reset pulsed 5 cycles after accepting 200/3 -> no result is emitted, ostream_val=0, and a following 9/3 returns (3,0) at normal latency.

Source files
------------

// File: rtl/aidan_mcnay_div_pool.sv
// ---------------------------------------------------------------------------
// aidan_mcnay_div_pool
//
// Pool of nunits restoring radix-2 unsigned dividers. Requests are issued
// round-robin to units and results are returned strictly in acceptance
// order. Each unit needs nbits cycles to resolve its quotient, so with
// several units the pool can overlap that many divisions.
//
// Parameters
//   nbits   operand/result width (2..32)
//   nunits  number of divider units (1..8)
//
// Ports
//   clk          sole clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   opa, opb     unsigned dividend / divisor
//   istream_val  request valid
//   istream_rdy  request ready (unit at the issue pointer is IDLE)
//   quotient     opa / opb   (0 while ostream_val is low)
//   remainder    opa % opb   (0 while ostream_val is low)
//   ostream_val  result valid (unit at the output pointer is DONE)
//   ostream_rdy  result ready
//   div_by_zero  only with AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN defined: high
//                with ostream_val when the emitted result had opb = 0
//
// Handshake: a transfer happens on a rising edge where val and rdy are both
// high; val never depends on rdy, and istream_rdy never depends on
// ostream_rdy, so a unit freed at an edge accepts from the next cycle.
//
// Optional feature macro: AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
// Per-unit FSM state is visible as the internal array unit_state.
// ---------------------------------------------------------------------------
module aidan_mcnay_div_pool #(
  parameter int nbits  = 16,
  parameter int nunits = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] opa,
  input  logic [nbits-1:0] opb,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] quotient,
  output logic [nbits-1:0] remainder,
  output logic             ostream_val,
  input  logic             ostream_rdy
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
  ,
  output logic             div_by_zero
`endif
);

  localparam int PW = (nunits > 1) ? $clog2(nunits) : 1;
  localparam int CW = $clog2(nbits);
  localparam logic [PW-1:0] LAST_PTR = PW'(nunits - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(nbits - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } unit_state_e;

  unit_state_e      unit_state   [nunits];
  unit_state_e      unit_state_n [nunits];
  // Partial remainder is one bit wider than the operands so the shifted
  // value can be compared with a divisor >= 2^(nbits-1) without overflow.
  logic [nbits:0]   rem_q [nunits];
  logic [nbits:0]   rem_n [nunits];
  // Holds the dividend; its MSB is shifted out each step while quotient
  // bits are shifted in at the LSB, so it ends up holding the quotient.
  logic [nbits-1:0] quo_q [nunits];
  logic [nbits-1:0] quo_n [nunits];
  logic [nbits-1:0] div_q [nunits];
  logic [nbits-1:0] div_n [nunits];
  logic [CW-1:0]    cnt_q [nunits];
  logic [CW-1:0]    cnt_n [nunits];
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
  logic             dbz_q [nunits];
  logic             dbz_n [nunits];
`endif

  logic [PW-1:0] iptr, iptr_n;
  logic [PW-1:0] optr, optr_n;
  logic          in_fire, out_fire;

  assign istream_rdy = !reset && (unit_state[iptr] == IDLE);
  assign ostream_val = !reset && (unit_state[optr] == DONE);
  assign in_fire     = istream_val && istream_rdy;
  assign out_fire    = ostream_val && ostream_rdy;

  assign quotient  = ostream_val ? quo_q[optr] : '0;
  assign remainder = ostream_val ? rem_q[optr][nbits-1:0] : '0;
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
  assign div_by_zero = ostream_val ? dbz_q[optr] : 1'b0;
`endif

  always_comb begin : next_state
    logic [nbits+1:0] shifted;
    logic [nbits+1:0] diff;
    logic             qbit;
    shifted = '0;
    diff    = '0;
    qbit    = 1'b0;
    iptr_n  = iptr;
    optr_n  = optr;
    if (in_fire) iptr_n = (iptr == LAST_PTR) ? '0 : iptr + 1'b1;
    if (out_fire) optr_n = (optr == LAST_PTR) ? '0 : optr + 1'b1;

    for (int i = 0; i < nunits; i++) begin
      unit_state_n[i] = unit_state[i];
      rem_n[i]        = rem_q[i];
      quo_n[i]        = quo_q[i];
      div_n[i]        = div_q[i];
      cnt_n[i]        = cnt_q[i];
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
      dbz_n[i]        = dbz_q[i];
`endif
      case (unit_state[i])
        IDLE: begin
          if (in_fire && (iptr == PW'(i))) begin
            unit_state_n[i] = BUSY;
            rem_n[i]        = '0;
            quo_n[i]        = opa;
            div_n[i]        = opb;
            cnt_n[i]        = '0;
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
            dbz_n[i]        = (opb == '0);
`endif
          end
        end
        BUSY: begin
          // Top bit of shifted is always 0: the stored remainder is below
          // the divisor, so it fits in nbits bits before the shift.
          shifted = {rem_q[i], quo_q[i][nbits-1]};
          diff    = shifted - {2'b00, div_q[i]};
          if (shifted >= {2'b00, div_q[i]}) begin
            rem_n[i] = diff[nbits:0];
            qbit     = 1'b1;
          end else begin
            rem_n[i] = shifted[nbits:0];
            qbit     = 1'b0;
          end
          quo_n[i] = {quo_q[i][nbits-2:0], qbit};
          cnt_n[i] = cnt_q[i] + 1'b1;
          if (cnt_q[i] == LAST_CNT) unit_state_n[i] = DONE;
        end
        DONE: begin
          if (out_fire && (optr == PW'(i))) unit_state_n[i] = IDLE;
        end
        default: unit_state_n[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      iptr <= '0;
      optr <= '0;
      for (int i = 0; i < nunits; i++) begin
        unit_state[i] <= IDLE;
        rem_q[i]      <= '0;
        quo_q[i]      <= '0;
        div_q[i]      <= '0;
        cnt_q[i]      <= '0;
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
        dbz_q[i]      <= 1'b0;
`endif
      end
    end else begin
      iptr <= iptr_n;
      optr <= optr_n;
      for (int i = 0; i < nunits; i++) begin
        unit_state[i] <= unit_state_n[i];
        rem_q[i]      <= rem_n[i];
        quo_q[i]      <= quo_n[i];
        div_q[i]      <= div_n[i];
        cnt_q[i]      <= cnt_n[i];
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
        dbz_q[i]      <= dbz_n[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_aidan_mcnay_div_pool.sv
// ---------------------------------------------------------------------------
// tb_aidan_mcnay_div_pool
//
// Directed plus short random stimulus for aidan_mcnay_div_pool (nbits=16,
// nunits=2). Expected {div_by_zero, quotient, remainder} entries are pushed
// when a request is accepted and popped by the output monitor on each
// output handshake. Inputs change 1 time unit after the rising edge; the
// monitor samples on the falling edge.
// ---------------------------------------------------------------------------
module tb_aidan_mcnay_div_pool;

  localparam int NB = 16;
  localparam int NU = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] opa, opb;
  logic          istream_val;
  logic          istream_rdy;
  logic [NB-1:0] quotient, remainder;
  logic          ostream_val;
  logic          ostream_rdy;
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
  logic          div_by_zero;
`endif

  int checks  = 0;
  int errors  = 0;
  int accepts = 0;

  logic [2*NB:0] exp_q[$];
  logic [2*NB:0] mon_e;

  aidan_mcnay_div_pool #(.nbits(NB), .nunits(NU)) dut (
    .clk         (clk),
    .reset       (reset),
    .opa         (opa),
    .opb         (opb),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .quotient    (quotient),
    .remainder   (remainder),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy)
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
    ,
    .div_by_zero (div_by_zero)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result: {div_by_zero, quotient, remainder}.
  function automatic logic [2*NB:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b);
    if (b == '0) return {1'b1, {NB{1'b1}}, a};
    return {1'b0, a / b, a % b};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and holds it until accepted; 'waited' is the number
  // of cycles it was refused. With jitter set, ostream_rdy is randomised
  // every cycle while waiting.
  task automatic send(input logic [NB-1:0] a, input logic [NB-1:0] b,
                      input bit jitter, output int waited);
    opa         = a;
    opb         = b;
    istream_val = 1'b1;
    waited      = 0;
    while (!istream_rdy && waited < 200) begin
      if (jitter) ostream_rdy = 1'($urandom_range(0, 1));
      tick();
      waited++;
    end
    chk("request_accepted", istream_rdy, 1);
    if (istream_rdy) begin
      exp_q.push_back(model(a, b));
      tick();
    end
    istream_val = 1'b0;
  endtask

  // Sends into an empty pool with ostream_rdy high and checks the exact
  // cycle ostream_val rises: at the nbits-th edge after acceptance.
  task automatic send_timed(input logic [NB-1:0] a, input logic [NB-1:0] b,
                            input logic [NB-1:0] eq, input logic [NB-1:0] er);
    int w;
    ostream_rdy = 1'b1;
    send(a, b, 1'b0, w);
    repeat (NB - 1) tick();
    chk("latency_not_early", ostream_val, 0);
    tick();
    chk("latency_val", ostream_val, 1);
    chk("latency_quotient", quotient, eq);
    chk("latency_remainder", remainder, er);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ostream_rdy = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset && istream_val && istream_rdy) accepts++;
    if (ostream_val === 1'b1) begin
      if (ostream_rdy) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", ostream_val, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_quotient", quotient, mon_e[2*NB-1:NB]);
          chk("sb_remainder", remainder, mon_e[NB-1:0]);
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
          chk("sb_div_by_zero", div_by_zero, mon_e[2*NB]);
`endif
        end
      end
    end else begin
      chk("idle_quotient_zero", quotient, 0);
      chk("idle_remainder_zero", remainder, 0);
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
      chk("idle_dbz_zero", div_by_zero, 0);
`endif
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int acc0;
    logic [NB-1:0] ra, rb;

    reset       = 1'b1;
    opa         = '0;
    opb         = '0;
    istream_val = 1'b0;
    ostream_rdy = 1'b0;
    repeat (3) tick();
    chk("reset_istream_rdy", istream_rdy, 0);
    chk("reset_ostream_val", ostream_val, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    reset = 1'b0;
    #1;
    chk("post_reset_istream_rdy", istream_rdy, 1);
    tick();

    // 100/7: latency and values
    send_timed(16'd100, 16'd7, 16'd14, 16'd2);
    drain();

    // Boundary operands, back to back
    ostream_rdy = 1'b1;
    send(16'hFFFF, 16'h0001, 1'b0, w);
    send(16'h8000, 16'h8001, 1'b0, w);
    drain();

    // Divide by zero
    send_timed(16'd1234, 16'd0, 16'hFFFF, 16'd1234);
`ifdef AIDAN_MCNAY_DIV_POOL_DBZ_FLAG_EN
    chk("dbz_flag", div_by_zero, 1);
`endif
    drain();

    // Back-to-back with output backpressure; third request must wait
    ostream_rdy = 1'b0;
    acc0 = accepts;
    send(16'd50, 16'd5, 1'b0, w);
    send(16'd9, 16'd4, 1'b0, w);
    opa         = 16'd7;
    opb         = 16'd7;
    istream_val = 1'b1;
    for (int k = 0; k < 46; k++) begin
      chk("full_istream_rdy_low", istream_rdy, 0);
      if (k >= 16) begin
        chk("hold_ostream_val", ostream_val, 1);
        chk("hold_quotient", quotient, 16'd10);
        chk("hold_remainder", remainder, 16'd0);
      end
      tick();
    end
    chk("accepted_while_full", accepts - acc0, 2);
    ostream_rdy = 1'b1;
    send(16'd7, 16'd7, 1'b0, w);
    chk("third_waits_one_cycle", w, 1);
    drain();

    // Reset mid-operation discards in-flight work
    ostream_rdy = 1'b1;
    send(16'd200, 16'd3, 1'b0, w);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    chk("midreset_ostream_val", ostream_val, 0);
    chk("midreset_istream_rdy", istream_rdy, 0);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("midreset_rdy_rise", istream_rdy, 1);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("midreset_no_output", ostream_val, 0);
    end
    send_timed(16'd9, 16'd3, 16'd3, 16'd0);
    drain();

    // Random requests with random output backpressure
    for (int k = 0; k < 12; k++) begin
      ra = NB'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       rb = '0;
        1:       rb = NB'($urandom_range(1, 15));
        2:       rb = NB'($urandom_range(16'h8000, 16'hFFFF));
        default: rb = NB'($urandom_range(1, 65535));
      endcase
      ostream_rdy = 1'($urandom_range(0, 1));
      send(ra, rb, 1'b1, w);
      repeat ($urandom_range(0, 3)) begin
        ostream_rdy = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
